// File: rtl/hs_read_pkg.sv
// Shared types and width helpers for the multi-channel handshake read sequencer.
package hs_read_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_1,
        WAIT_0,
        DONE,
        ERR
    } state_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Word counter width; holds 0..words-1.
    function automatic int word_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Timeout counter width; holds 0..timeout (timeout 0 keeps a dummy bit).
    function automatic int tmo_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/hs_read_seq_sync.sv
// Multi-bit level synchroniser: STAGES flops per bit, cleared by reset.
module sync_bits #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous levels through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every stage is reset so no stale handshake level survives reset.
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/hs_read_seq.sv
// Handshake read sequencer: walks NUM_CH channels, WORDS reads each, waiting
// for each producer's ready level to rise (read strobe) and fall (next word).
module hs_read_seq
    import hs_read_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int WORDS       = 1,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              abort,
    input  logic [NUM_CH-1:0] handshake,
    output logic [NUM_CH-1:0] read,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int WORD_W = word_w(WORDS);
    localparam int TMO_W  = tmo_w(TIMEOUT);

    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_CH-1:0] ONE_HOT0  = NUM_CH'(1);

    state_t             state;
    logic [CH_W-1:0]    ch;
    logic [WORD_W-1:0]  word;
    logic [TMO_W-1:0]   tcnt;
    logic [TMO_W-1:0]   tcnt_inc;
    logic [NUM_CH-1:0]  hs_s;
    logic               hs_cur;
    logic               tmo_hit;

    sync_bits #(
        .WIDTH  (NUM_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (handshake),
        .q       (hs_s)
    );

    assign hs_cur   = hs_s[ch];
    // The cycle counted now is the TIMEOUT-th one spent in this wait phase.
    assign tmo_hit  = (TIMEOUT > 0) && (tcnt == TMO_LAST);
    assign tcnt_inc = (TIMEOUT > 0) ? tcnt + 1'b1 : '0;

    // Sequencer FSM with registered read strobe and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            read  <= '0;
            ch    <= '0;
            word  <= '0;
            tcnt  <= '0;
        end else begin
            // NOTE: non-blocking throughout, and read defaults low so the strobe
            // is a single cycle whatever branch is taken below.
            read <= '0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= WAIT_1;
                        ch    <= '0;
                        word  <= '0;
                        tcnt  <= '0;
                    end
                end
                WAIT_1: begin
                    if (abort) begin
                        state <= IDLE;
                        ch    <= '0;
                        word  <= '0;
                        tcnt  <= '0;
                    end else if (tmo_hit) begin
                        state <= ERR;
                        tcnt  <= '0;
                    end else if (hs_cur) begin
                        state <= WAIT_0;
                        read  <= ONE_HOT0 << ch;
                        tcnt  <= '0;
                    end else begin
                        tcnt  <= tcnt_inc;
                    end
                end
                WAIT_0: begin
                    if (abort) begin
                        state <= IDLE;
                        ch    <= '0;
                        word  <= '0;
                        tcnt  <= '0;
                    end else if (tmo_hit) begin
                        state <= ERR;
                        tcnt  <= '0;
                    end else if (!hs_cur) begin
                        tcnt <= '0;
                        if (word == LAST_WORD) begin
                            if (ch == LAST_CH) begin
                                state <= DONE;
                            end else begin
                                state <= WAIT_1;
                                ch    <= ch + 1'b1;
                                word  <= '0;
                            end
                        end else begin
                            state <= WAIT_1;
                            word  <= word + 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ch    <= '0;
                    word  <= '0;
                    tcnt  <= '0;
                end
                ERR: begin
                    if (abort) begin
                        state <= IDLE;
                        ch    <= '0;
                        word  <= '0;
                        tcnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ch_idx = ch;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE) && !abort;
    assign error  = (state == ERR);

endmodule

// File: doc/hs_read_seq.md
HS_READ_SEQ -- requirements
Module: hs_read_seq

Interface
REQ-001 Parameter NUM_CH, default 2: number of handshake channels (>=1).
REQ-002 Parameter WORDS, default 1: reads performed per channel per run (>=1).
REQ-003 Parameter TIMEOUT, default 1023: max cycles waited in any handshake phase; 0 disables timeout.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth on handshake inputs (>=1).
REQ-005 Port clk  in  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-006 Port reset_n  in  1  asynchronous active-low reset.
REQ-007 Port run  in  1  start request, sampled only in IDLE.
REQ-008 Port abort  in  1  cancel current sequence.
REQ-009 Port handshake  in  NUM_CH  per-channel producer ready level, asynchronous to clk.
REQ-010 Port read  out  NUM_CH  one-cycle read strobe, one-hot or zero.
REQ-011 Port ch_idx  out  CH_W=max(1,$clog2(NUM_CH))  channel currently serviced.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port done  out  1  one-cycle completion flag.
REQ-014 Port error  out  1  high while in ERR.

Function
REQ-015 States SHALL be IDLE, WAIT_1, WAIT_0, DONE, ERR.
REQ-016 handshake SHALL pass through SYNC_STAGES flops before use; the FSM SHALL see only hs_s.
REQ-017 IDLE: run high -> WAIT_1 next cycle with ch_idx=0, word count=0; run in any other state SHALL be ignored.
REQ-018 WAIT_1: hs_s[ch_idx] high -> WAIT_0, and read[ch_idx] SHALL be high for exactly the following cycle (registered).
REQ-019 Latency from handshake pin rise to read strobe SHALL be SYNC_STAGES+1 cycles.
REQ-020 WAIT_0: hs_s[ch_idx] low -> word==WORDS-1 && ch_idx==NUM_CH-1 gives DONE; word==WORDS-1 gives ch_idx+1, word=0, WAIT_1; otherwise word+1, WAIT_1.
REQ-021 DONE: done=1 decoded combinationally from state for one cycle, then IDLE.
REQ-022 Timeout counter SHALL clear on each entry to WAIT_1/WAIT_0 and increment each cycle there; reaching TIMEOUT (TIMEOUT>0) SHALL move to ERR.
REQ-023 ERR SHALL hold with error=1 until abort high, then IDLE; run ignored in ERR.
REQ-024 abort high in WAIT_1, WAIT_0 or DONE SHALL force IDLE next cycle, suppress read and done that cycle, clear counters.
REQ-025 Priority per cycle: abort > timeout > handshake progress.
REQ-026 NUM_CH=1, WORDS=1 SHALL behave identically to the single-channel read sequencer (plus sync latency).
REQ-027 Counters SHALL never wrap: ch_idx max NUM_CH-1, word max WORDS-1, timeout max TIMEOUT.

Reset
REQ-028 On reset_n low: state=IDLE, read=0, ch_idx=0, word=0, timeout count=0, synchroniser flops=0; busy/done/error therefore 0.
REQ-029 Reset asserted mid-sequence SHALL abandon it with no done/read pulse after release.

Structure
REQ-030 Package hs_read_pkg SHALL hold the state enum and CH_W/word/timeout width functions.
REQ-031 Sub-module sync_bits (WIDTH, STAGES, async reset to 0) SHALL implement the synchroniser.

Verification
REQ-032 NUM_CH=3, WORDS=2: run pulse, each handshake toggles high 4 cycles/low 4 cycles -> 6 read strobes order ch0,ch0,ch1,ch1,ch2,ch2, then single done.
REQ-033 Default params: handshake rises at cycle 10 in WAIT_1 -> read[0] high only at cycle 13.
REQ-034 TIMEOUT=8: run, handshake held low -> error high 8 cycles after WAIT_1 entry; abort -> IDLE, error 0, no done.
REQ-035 abort asserted same cycle hs_s rises in WAIT_1 -> no read strobe, IDLE next cycle.
REQ-036 reset_n pulsed low while in WAIT_0 of ch1 -> all outputs 0 immediately; subsequent run restarts at ch0.
REQ-037 run held high continuously -> back-to-back sequences, exactly one done per sequence, one IDLE cycle between.
